// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with hold-until-release and a timeout-forced revoke.
// Latency: a request sampled in IDLE is granted at that edge; all outputs are registered.
// Backpressure: the owner keeps the grant until done, its request drops, or TIMEOUT cycles elapse.
module rr_arbiter_8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Counter value at the last permitted grant cycle; irrelevant when the timeout is disabled.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic       TO_EN    = (TIMEOUT != 0);

  logic [0:0] state;
  logic [2:0] last;
  logic [7:0] cnt;

  logic [2:0] win;
  logic       win_vld;
  logic       release_hit;
  logic       timeout_hit;

  // Rotating-priority search: first set request starting just after the last winner.
  always_comb begin
    win     = 3'd0;
    win_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!win_vld && req[last + 3'(k)]) begin
        win     = last + 3'(k);
        win_vld = 1'b1;
      end
    end
  end

  // Release by the owner takes precedence over a coincident timeout.
  always_comb begin
    release_hit = done || !req[gnt_id];
    timeout_hit = TO_EN && (cnt == CNT_LAST);
  end

  // Grant state machine: IDLE picks a winner, GRANT holds until release or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last      <= 3'd7;
      cnt       <= 8'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= GRANT;
            gnt       <= 8'd1 << win;
            gnt_id    <= win;
            gnt_valid <= 1'b1;
            last      <= win;
            cnt       <= 8'd0;
          end
        end
        GRANT: begin
          if (release_hit) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
          end else if (timeout_hit) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 8'h00;
          gnt_id    <= 3'd0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: a TIMEOUT=16 instance and a TIMEOUT=0 instance.
// Directed stimulus with literal expectations plus a per-cycle reference model.
// Inputs change 1 time unit after the rising edge; the model compares on the falling edge.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst, done, b_rst, b_done;
  logic [7:0] req, b_req;
  logic [7:0] gnt, b_gnt;
  logic [2:0] gnt_id, b_gnt_id;
  logic       gnt_valid, timeout, b_gnt_valid, b_timeout;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  rr_arbiter_8 #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst(b_rst), .req(b_req), .done(b_done),
    .gnt(b_gnt), .gnt_id(b_gnt_id), .gnt_valid(b_gnt_valid), .timeout(b_timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when idle), last winner, cycles the grant has been visible.
  int m_owner[2];
  int m_last[2];
  int m_held[2];
  bit m_tmo[2];

  task automatic step(input int i, input int to, input logic rs, input logic [7:0] r, input logic d);
    if (rs) begin
      m_owner[i] = -1; m_last[i] = 7; m_held[i] = 0; m_tmo[i] = 0;
    end else if (m_owner[i] < 0) begin
      m_tmo[i] = 0;
      for (int k = 1; k <= 8; k++) begin
        int idx;
        idx = (m_last[i] + k) % 8;
        if (m_owner[i] < 0 && r[idx]) begin
          m_owner[i] = idx; m_last[i] = idx; m_held[i] = 1;
        end
      end
    end else begin
      m_tmo[i] = 0;
      if (d || !r[m_owner[i]]) m_owner[i] = -1;
      else if (to != 0 && m_held[i] == to) begin
        m_owner[i] = -1; m_tmo[i] = 1;
      end else m_held[i]++;
    end
  endtask

  task automatic cmp(input int i, input logic [7:0] g, input logic [2:0] id, input logic v, input logic t);
    int eg, eid;
    eg  = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
    eid = (m_owner[i] >= 0) ? m_owner[i] : 0;
    chk($sformatf("model%0d.gnt", i), int'(g), eg);
    chk($sformatf("model%0d.gnt_id", i), int'(id), eid);
    chk($sformatf("model%0d.gnt_valid", i), int'(v), int'(m_owner[i] >= 0));
    chk($sformatf("model%0d.timeout", i), int'(t), int'(m_tmo[i]));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_last[i] = 7; m_held[i] = 0; m_tmo[i] = 0;
    end
  end

  always @(posedge clk) begin
    step(0, 16, rst, req, done);
    step(1, 0, b_rst, b_req, b_done);
  end

  always @(negedge clk) begin
    if (started) begin
      cmp(0, gnt, gnt_id, gnt_valid, timeout);
      cmp(1, b_gnt, b_gnt_id, b_gnt_valid, b_timeout);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; done = 0; req = 8'h00;
    b_rst = 1; b_done = 0; b_req = 8'h00;
    cyc(2);
    started = 1;
    chk("reset.gnt", int'(gnt), 0);
    chk("reset.gnt_id", int'(gnt_id), 0);
    chk("reset.gnt_valid", int'(gnt_valid), 0);
    chk("reset.timeout", int'(timeout), 0);
    rst = 0; b_rst = 0;

    // Full round robin with one-cycle owners: 0..7 then wrap to 0.
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk("rr.gnt_id", int'(gnt_id), i % 8);
      chk("rr.gnt", int'(gnt), 1 << (i % 8));
      done = 1;
      cyc(1);
      chk("rr.idle", int'(gnt_valid), 0);
      done = 0;
    end

    // Grant 5, then 0010_0100 wraps past 7 to 2, then 5.
    req = 8'h20;
    cyc(1);
    chk("wrap.first", int'(gnt_id), 5);
    done = 1; cyc(1); done = 0;
    req = 8'b0010_0100;
    cyc(1);
    chk("wrap.to2", int'(gnt_id), 2);
    done = 1; cyc(1); done = 0;
    cyc(1);
    chk("wrap.to5", int'(gnt_id), 5);
    req = 8'h00; cyc(1);
    chk("wrap.idle", int'(gnt_valid), 0);

    // Timeout: exactly 16 visible cycles, then a one-cycle pulse with gnt low.
    req = 8'h08;
    cyc(1);
    for (int k = 0; k < 16; k++) begin
      chk("tmo.hold", int'(gnt), 8'h08);
      chk("tmo.nopulse", int'(timeout), 0);
      cyc(1);
    end
    chk("tmo.gnt_drop", int'(gnt), 0);
    chk("tmo.pulse", int'(timeout), 1);
    cyc(1);
    chk("tmo.regrant3", int'(gnt), 8'h08);
    chk("tmo.pulse_end", int'(timeout), 0);
    // Client 4 arrives mid-grant: ignored until the next IDLE, then wins.
    req = 8'h18;
    cyc(15);
    chk("tmo2.hold", int'(gnt), 8'h08);
    cyc(1);
    chk("tmo2.pulse", int'(timeout), 1);
    cyc(1);
    chk("tmo2.next4", int'(gnt_id), 4);

    // Owner drops its request: release, no timeout pulse.
    req = 8'h00;
    cyc(1);
    chk("drop.gnt", int'(gnt), 0);
    chk("drop.timeout", int'(timeout), 0);
    done = 1; cyc(1);
    chk("idle_done.valid", int'(gnt_valid), 0);
    req = 8'h04; cyc(1);
    chk("idle_done.grant2", int'(gnt_id), 2);
    done = 0; req = 8'h00; cyc(1);

    // Reset mid-grant restores last=7.
    req = 8'h40; cyc(1);
    chk("rst.gnt6", int'(gnt_id), 6);
    cyc(2);
    rst = 1; req = 8'hFF; cyc(1);
    chk("rst.gnt", int'(gnt), 0);
    chk("rst.valid", int'(gnt_valid), 0);
    chk("rst.timeout", int'(timeout), 0);
    rst = 0; cyc(1);
    chk("rst.next0", int'(gnt_id), 0);
    req = 8'h00;

    // TIMEOUT=0 instance holds indefinitely.
    b_req = 8'h02;
    cyc(1);
    for (int k = 0; k < 300; k++) begin
      chk("notmo.hold", int'(b_gnt), 8'h02);
      chk("notmo.pulse", int'(b_timeout), 0);
      cyc(1);
    end
    b_done = 1; cyc(1);
    chk("notmo.release", int'(b_gnt_valid), 0);
    b_done = 0; b_req = 8'h00;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
